// File: rtl/display_scanner_if.sv
// Digit-scan bus between the count source, the scanner and the downstream
// hex7seg decoder / anode drivers.
interface display_scanner_if;
    logic        en;
    logic [15:0] value;
    logic        neg;
    logic [3:0]  n;
    logic        dash;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output en, value, neg,
        input  n, dash, an, frame_tick
    );

    modport slave (
        input  en, value, neg,
        output n, dash, an, frame_tick
    );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexes a latched 16-bit count onto a 4-digit common-anode display,
// one digit slot per 2**DIV_W clocks, with optional leading-zero blanking.
module display_scanner #(
    parameter int unsigned DIV_W = 17,
    parameter bit          LZB   = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    display_scanner_if.slave bus
);
    logic [DIV_W-1:0] div_cnt;
    logic             strobe;
    logic [1:0]       idx;
    logic [15:0]      val_s;
    logic             neg_s;
    logic             frame_tick_q;
    logic [3:0]       an_q;
    logic [3:0]       n_q;
    logic             dash_q;

    logic [3:0]       nib_zero;
    logic             upper_zero;
    logic             is_dash;
    logic             is_blank;
    logic [3:0]       an_d;
    logic [3:0]       n_d;
    logic             dash_d;

    assign strobe = &div_cnt;

    // Snapshot only at the slot-3 -> slot-0 boundary so a frame never mixes values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            idx          <= '0;
            val_s        <= '0;
            neg_s        <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt      <= div_cnt + DIV_W'(1);
            frame_tick_q <= 1'b0;
            if (strobe) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    val_s        <= bus.value;
                    neg_s        <= bus.neg;
                    frame_tick_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        nib_zero = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            nib_zero[k] = (val_s[4*k +: 4] == 4'h0);
        end

        // Nibble 3 only counts toward the zero run when it is not the sign slot.
        case (idx)
            2'd1:    upper_zero = nib_zero[1] & nib_zero[2] & (neg_s | nib_zero[3]);
            2'd2:    upper_zero = nib_zero[2] & (neg_s | nib_zero[3]);
            2'd3:    upper_zero = nib_zero[3];
            default: upper_zero = 1'b0;
        endcase

        is_dash  = neg_s && (idx == 2'd3);
        is_blank = LZB && !is_dash && upper_zero;

        an_d   = ~(4'b0001 << idx);
        n_d    = val_s[{idx, 2'b00} +: 4];
        dash_d = 1'b0;

        if (is_dash) begin
            n_d    = '0;
            dash_d = 1'b1;
        end else if (is_blank) begin
            an_d = '1;
            n_d  = '0;
        end

        if (!bus.en) begin
            an_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q   <= '1;
            n_q    <= '0;
            dash_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            n_q    <= n_d;
            dash_q <= dash_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.n          = n_q;
    assign bus.dash       = dash_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: stimulus queues one expected frame per
// snapshot, a monitor replays each frame slot by slot against both LZB builds.
module tb_display_scanner;
    localparam int NFR = 14;

    typedef struct {
        logic [15:0] v;
        logic        ng;
        logic        e;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic [15:0] value;
    logic        neg;

    int checks = 0;
    int errors = 0;

    frame_t exp_q[$];
    logic [15:0] sv[NFR];
    logic        sn[NFR];
    logic        se[NFR];

    always #5 clk = ~clk;

    display_scanner_if bus1();
    display_scanner_if bus0();

    assign bus1.en    = en;
    assign bus1.value = value;
    assign bus1.neg   = neg;
    assign bus0.en    = en;
    assign bus0.value = value;
    assign bus0.neg   = neg;

    display_scanner #(.DIV_W(2), .LZB(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    display_scanner #(.DIV_W(2), .LZB(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        $display("FAIL %s: timed out waiting for frame_tick", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    endtask

    // Expected {an, n, dash} for one slot, from the display rules directly.
    function automatic logic [8:0] exp_out(input frame_t f, input int slot, input bit lzb);
        logic [3:0] d[4];
        logic [3:0] an_e;
        logic [3:0] n_e;
        logic       dash_e;
        int top;
        int highest;
        for (int k = 0; k < 4; k++) d[k] = 4'((f.v >> (4 * k)) & 16'hF);
        top = f.ng ? 2 : 3;
        highest = 0;
        for (int k = 0; k <= top; k++) if (d[k] != 4'h0) highest = k;
        an_e   = ~(4'(1) << slot);
        n_e    = d[slot];
        dash_e = 1'b0;
        if (f.ng && slot == 3) begin
            n_e    = 4'h0;
            dash_e = 1'b1;
        end else if (lzb && slot > highest) begin
            an_e = 4'hF;
            n_e  = 4'h0;
        end
        if (!f.e) an_e = 4'hF;
        return {an_e, n_e, dash_e};
    endfunction

    task automatic wait_tick(input string name);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt > 40) abort(name);
        end while (bus1.frame_tick !== 1'b1);
    endtask

    task automatic run_stim();
        frame_t prev;
        prev = '{v: 16'h0000, ng: 1'b0, e: 1'b1};
        for (int k = 0; k < NFR; k++) begin
            wait_tick("stim_tick");
            en = se[k];
            exp_q.push_back('{v: prev.v, ng: prev.ng, e: se[k]});
            value = 16'($urandom);
            neg   = 1'($urandom);
            repeat ($urandom_range(1, 8)) @(negedge clk);
            value = sv[k];
            neg   = sn[k];
            prev  = '{v: sv[k], ng: sn[k], e: se[k]};
        end
    endtask

    task automatic run_monitor();
        frame_t rec;
        logic [8:0] act1;
        logic [8:0] act0;
        wait_tick("mon_first_tick");
        for (int w = 0; w < NFR; w++) begin
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                if (j == 1) begin
                    if (exp_q.size() == 0) abort("queue_empty");
                    rec = exp_q.pop_front();
                end
                act1 = {bus1.an, bus1.n, bus1.dash};
                act0 = {bus0.an, bus0.n, bus0.dash};
                check($sformatf("lzb1 frame%0d slot%0d {an,n,dash}", w, (j - 1) / 4),
                      32'(act1), 32'(exp_out(rec, (j - 1) / 4, 1'b1)));
                check($sformatf("lzb0 frame%0d slot%0d {an,n,dash}", w, (j - 1) / 4),
                      32'(act0), 32'(exp_out(rec, (j - 1) / 4, 1'b0)));
                check($sformatf("frame_tick frame%0d cyc%0d", w, j),
                      32'(bus1.frame_tick), 32'(j == 16));
            end
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [15:0] masks[4];
        masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF; masks[3] = 16'h000F;

        sv[0] = 16'h12AF; sn[0] = 1'b0; se[0] = 1'b1;
        sv[1] = 16'h0005; sn[1] = 1'b0; se[1] = 1'b1;
        sv[2] = 16'h0030; sn[2] = 1'b1; se[2] = 1'b1;
        sv[3] = 16'h1111; sn[3] = 1'b0; se[3] = 1'b1;
        sv[4] = 16'h2222; sn[4] = 1'b0; se[4] = 1'b1;
        sv[5] = 16'h12AF; sn[5] = 1'b0; se[5] = 1'b0;
        sv[6] = 16'h0000; sn[6] = 1'b0; se[6] = 1'b1;
        sv[7] = 16'h0000; sn[7] = 1'b1; se[7] = 1'b1;
        for (int k = 8; k < NFR; k++) begin
            sv[k] = 16'($urandom) & masks[$urandom_range(0, 3)];
            sn[k] = 1'($urandom);
            se[k] = ($urandom_range(0, 3) != 0);
        end

        en = 1'b1; value = 16'h0000; neg = 1'b0;
        repeat (2) @(negedge clk);
        check("reset an", 32'(bus1.an), 32'hF);
        check("reset n", 32'(bus1.n), 32'h0);
        check("reset dash", 32'(bus1.dash), 32'h0);
        check("reset frame_tick", 32'(bus1.frame_tick), 32'h0);
        rst_n = 1'b1;

        fork
            run_stim();
            run_monitor();
        join

        value = 16'h12AF; neg = 1'b0; en = 1'b1;
        repeat (21) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset an", 32'(bus1.an), 32'hF);
        check("async reset n", 32'(bus1.n), 32'h0);
        check("async reset dash", 32'(bus1.dash), 32'h0);
        check("async reset frame_tick", 32'(bus1.frame_tick), 32'h0);
        check("async reset an lzb0", 32'(bus0.an), 32'hF);

        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus1.frame_tick !== 1'b1 && cnt < 40);
        check("cycles from reset to first frame_tick", 32'(cnt), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
